// File: rtl/proc_pkg.sv
// Shared processor package: memory arbiter state encodings, requester IDs
// and the default memory address/data widths used across the processor.
package proc_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    // Requester IDs; also the bit positions in the one-hot grant vector
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational 2-way picker for the memory arbiter.
// Ports:
//   i_req   - fetch request
//   d_req   - data request
//   ptr     - last winner (REQ_FETCH/REQ_DATA), used only when rr_mode = 1
//   rr_mode - 1 = round-robin tie break, 0 = fixed priority (data wins)
//   gnt     - one-hot grant, bit REQ_FETCH / bit REQ_DATA, zero when idle
module arb_pick (
    input  logic       i_req,
    input  logic       d_req,
    input  logic       ptr,
    input  logic       rr_mode,
    output logic [1:0] gnt
);
    import proc_pkg::*;

    // On a tie, round-robin serves whoever did not win last; otherwise data wins
    always_comb begin
        gnt = 2'b00;
        if (i_req && d_req) begin
            if (rr_mode && (ptr == REQ_DATA)) begin
                gnt[REQ_FETCH] = 1'b1;
            end else begin
                gnt[REQ_DATA] = 1'b1;
            end
        end else if (d_req) begin
            gnt[REQ_DATA] = 1'b1;
        end else if (i_req) begin
            gnt[REQ_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port, synchronous-read memory between the
// instruction-fetch port (read-only) and the data port (load/store).
// One access at a time, fixed IDLE -> ACCESS -> RESP sequence.
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking;
// default is fixed priority, data over fetch.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   i_req/i_addr/i_ack/i_rdata     - fetch handshake and read data
//   d_req/d_we/d_addr/d_wdata      - data request, write enable, addr, store data
//   d_ack/d_rdata                  - data completion and load data
//   mem_en/mem_we/mem_addr/mem_wdata - registered memory controls
//   mem_rdata                      - memory read data, valid the cycle after mem_en
module mem_arbiter #(
    parameter int unsigned ADDR_W = proc_pkg::ADDR_W,
    parameter int unsigned DATA_W = proc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import proc_pkg::*;

    arb_state_e        state_q, state_d;
    logic              win_q, win_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [1:0]        gnt;
    logic              ptr;
    logic              rr_mode;
    logic              grant;

    assign grant = (state_q == ARB_IDLE) && (gnt != 2'b00);

`ifdef MEM_ARB_RR_EN
    logic ptr_q;

    // Last winner; reset to fetch so data wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= REQ_FETCH;
        end else if (grant) begin
            ptr_q <= gnt[REQ_DATA];
        end
    end

    assign ptr     = ptr_q;
    assign rr_mode = 1'b1;
`else
    assign ptr     = REQ_FETCH;
    assign rr_mode = 1'b0;
`endif

    arb_pick u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .ptr     (ptr),
        .rr_mode (rr_mode),
        .gnt     (gnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (gnt != 2'b00) state_d = ARB_ACCESS;
            ARB_ACCESS: state_d = ARB_RESP;
            ARB_RESP:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Output logic: next values of the registered memory controls and acks
    always_comb begin
        win_d       = win_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (gnt != 2'b00) begin
                    win_d    = gnt[REQ_DATA];
                    mem_en_d = 1'b1;
                    if (gnt[REQ_DATA]) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ARB_ACCESS: begin
                i_ack_d = (win_q == REQ_FETCH);
                d_ack_d = (win_q == REQ_DATA);
            end
            default: ;
        endcase
    end

    // Output and latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q       <= REQ_FETCH;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            win_q       <= win_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;

    // Read data is a straight path; qualified by the matching ack
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the processor's single-port, synchronous-read memory between two requesters: the instruction-fetch port (read-only) and the data port (load/store and writeback). The block sits between the processor's fetch/execute sequencing and the memory array. It owns every memory enable, address and write strobe, so exactly one access is in flight at a time. Each access uses a req/ack handshake and has a fixed 3-cycle grant-to-completion sequence.

## Interface
- ADDR_W, 12, memory word address width (matches the 12-bit instruction address fields)
- DATA_W, 32, memory and instruction word width
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- i_req  input  1  fetch request; held high until i_ack
- i_addr  input  ADDR_W  fetch address
- i_ack  output  1  one-cycle pulse; fetch complete, i_rdata valid
- i_rdata  output  DATA_W  fetched instruction word
- d_req  input  1  data request; held high until d_ack
- d_we  input  1  1 = store/writeback, 0 = load
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_ack  output  1  one-cycle pulse; access complete, d_rdata valid on loads
- d_rdata  output  DATA_W  load data
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en

## Operation
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: sample i_req and d_req. If neither is set, stay in IDLE. If one or both are set, pick a winner and latch its addr/we/wdata. Go to ACCESS.
- The fetch winner always has mem_we = 0 and mem_wdata = 0.
- ACCESS: mem_en = 1, with mem_we/mem_addr/mem_wdata taken from the latched values. Go to RESP.
- RESP: mem_en = 0. Pulse the winner's ack. The winner's rdata is driven from mem_rdata, and the value on a write ack is don't-care. Go to IDLE.
- If both requests are present in IDLE, arbitration follows the Configuration section.
- A requester that keeps req high after its ack is re-arbitrated in the next IDLE cycle. Back-to-back accesses are never merged.
- Dropping req before ack does not abort the access. The memory access still happens and the ack still pulses.
- Request inputs are ignored outside IDLE. The latched values are the only ones used.
- The losing requester is never acked. Its req stays pending.
- Reset values: state = IDLE, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, i_ack = 0, d_ack = 0, RR pointer = data-favoured.
- Reset asserted in ACCESS or RESP abandons the access. No ack is generated. If mem_en was already issued, the memory write may still land.

## Timing
- Request seen in IDLE in cycle N: mem_en is high in N+1, ack is high in N+2, IDLE again in N+3.
- Peak throughput is one access per 3 cycles.
- All FSM state, mem_* outputs and acks are registered. x_rdata is a direct combinational path from mem_rdata and is valid only while the matching ack is high.
- At most one of i_ack/d_ack is high in any cycle. Neither is ever high in the same cycle as mem_en.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last winner and updates on every grant.
  - On a tie, the requester that did not win last is served.
  - Reset value makes data win the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. The pointer register is not built.

## Structure
- Shared package proc_pkg holds:
  - the state encodings (ARB_IDLE, ARB_ACCESS, ARB_RESP)
  - requester IDs (REQ_FETCH = 0, REQ_DATA = 1)
  - the default ADDR_W/DATA_W constants, shared with the processor.
- One sub-module, arb_pick: a combinational 2-way picker with inputs (i_req, d_req, ptr, rr_mode) and one-hot grant output.

## Test plan
- Single fetch: i_req = 1, i_addr = 0x002, memory word 0x50000001 -> mem_en in N+1 with addr 0x002, we = 0; i_ack in N+2 with i_rdata = 0x50000001; d_ack never asserted.
- Single store then load: d_we = 1, d_addr = 0x001, d_wdata = 7 -> mem_we = 1 in N+1, d_ack in N+2. Then d_we = 0, d_addr = 0x001 -> d_rdata = 7.
- Tie, both builds:
  - With MEM_ARB_RR_EN: i_req and d_req held high for 4 accesses -> ack order D, I, D, I, every 3 cycles.
  - Without MEM_ARB_RR_EN: same stimulus -> D, D, D, D while d_req stays high.
- Early drop: d_req pulsed for 1 cycle only -> access still issued, d_ack still pulses at N+2, FSM returns to IDLE.
- Reset mid-access: reset asserted in the cycle after a grant -> next cycle state = IDLE, mem_en = 0, both acks 0, no ack for the abandoned request; a subsequent d_req is served normally.
- Mutual exclusion: random req streams for 1000 cycles -> i_ack & d_ack never both high, mem_en never high in an ack cycle, every req eventually acked with RR enabled.
